// File: rtl/mult_div_unit_if.sv
// Start/done bus between the datapath control FSM and the multiply/divide unit.
// The master issues operations; the slave returns the HI/LO pair and status pulses.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed/unsigned multiply and divide producing a HI/LO pair.
// Works on magnitudes, one bit per cycle, and fixes the signs in the FINISH cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clock_i,
    input  logic           reset_ni,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FINISH} state_t;

    state_t               state_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     opa_q;
    logic [WIDTH-1:0]     opb_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [CW-1:0]        cnt_q;
    logic                 is_div_q;
    logic                 neg_res_q;
    logic                 neg_rem_q;
    logic                 dbz_flag_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dbz_q;

    logic                 signed_d;
    logic                 a_neg_d;
    logic                 b_neg_d;
    logic [WIDTH-1:0]     a_abs_d;
    logic [WIDTH-1:0]     b_abs_d;
    logic [WIDTH:0]       mul_sum_d;
    logic [WIDTH:0]       div_shift_d;
    logic [WIDTH:0]       div_diff_d;
    logic                 div_ge_d;
    logic [CW-1:0]        cnt_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH-1:0]     quot_d;
    logic [WIDTH-1:0]     rem_d;

    always_comb begin
        signed_d    = ~bus.op[0];
        a_neg_d     = signed_d & bus.a[WIDTH-1];
        b_neg_d     = signed_d & bus.b[WIDTH-1];
        a_abs_d     = a_neg_d ? -bus.a : bus.a;
        b_abs_d     = b_neg_d ? -bus.b : bus.b;
        mul_sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
        div_shift_d = {rem_q, acc_q[WIDTH-1]};
        div_diff_d  = div_shift_d - {1'b0, opb_q};
        // Partial remainder is always below 2*divisor, so the MSB is a clean borrow.
        div_ge_d    = ~div_diff_d[WIDTH];
        cnt_d       = cnt_q - 1'b1;
        prod_d      = neg_res_q ? -acc_q : acc_q;
        quot_d      = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_d       = neg_rem_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            rem_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q    <= 1'b1;
                        is_div_q  <= bus.op[1];
                        opa_q     <= a_abs_d;
                        opb_q     <= b_abs_d;
                        rem_q     <= '0;
                        cnt_q     <= CW'(WIDTH);
                        neg_res_q <= a_neg_d ^ b_neg_d;
                        neg_rem_q <= a_neg_d;
                        if (bus.op[1]) begin
                            acc_q <= {{WIDTH{1'b0}}, a_abs_d};
                            if (bus.b == '0) begin
                                dbz_flag_q <= 1'b1;
                                state_q    <= S_FINISH;
                            end else begin
                                state_q <= S_DIV;
                            end
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, b_abs_d};
                            state_q <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= {mul_sum_d, acc_q[WIDTH-1:1]};
                    cnt_q <= cnt_d;
                    if (cnt_d == '0) state_q <= S_FINISH;
                end
                S_DIV: begin
                    rem_q              <= div_ge_d ? div_diff_d[WIDTH-1:0] : div_shift_d[WIDTH-1:0];
                    acc_q[WIDTH-1:0]   <= {acc_q[WIDTH-2:0], div_ge_d};
                    cnt_q              <= cnt_d;
                    if (cnt_d == '0) state_q <= S_FINISH;
                end
                S_FINISH: begin
                    if (!dbz_flag_q) begin
                        if (is_div_q) begin
                            hi_q <= rem_d;
                            lo_q <= quot_d;
                        end else begin
                            hi_q <= prod_d[2*WIDTH-1:WIDTH];
                            lo_q <= prod_d[WIDTH-1:0];
                        end
                    end
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    dbz_q      <= dbz_flag_q;
                    dbz_flag_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule
